// File: rtl/dma_block_writer.sv
// dma_block_writer: bus-mastering DMA that copies cmd_blocks 64-bit blocks from an external
// device into memory, holding each write for WR_CYCLES cycles and releasing the bus when not granted.
module dma_block_writer #(
    parameter int WR_CYCLES = 4,
    parameter bit PREEMPT   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd,
    input  logic [15:0] cmd_addr,
    input  logic [3:0]  cmd_blocks,
    output logic        BR,
    input  logic        BG,
    input  logic [63:0] edata,
    output logic [3:0]  offset,
    output logic        d_writeM,
    output logic [15:0] d_address,
    output logic [63:0] d_data,
    output logic        interrupt,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, REQ, XFER, GAP, DONE} state_t;

    state_t      r_state;
    logic [15:0] r_base;
    logic [3:0]  r_n;
    logic [3:0]  r_blk;
    logic [3:0]  r_beat;
    logic [3:0]  r_off;
    logic        r_br;
    logic        r_int;
    logic        r_busy;
    logic        w_own;
    logic        w_last_beat;
    logic        w_last_blk;

    // The bus is only driven while the grant is actually present, so a dropped BG releases it at once.
    assign w_own       = (r_state == XFER) && BG;
    assign w_last_beat = r_beat == 4'(WR_CYCLES - 1);
    assign w_last_blk  = (r_blk + 4'd1) == r_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_n     <= '0;
            r_blk   <= '0;
            r_beat  <= '0;
            r_off   <= '0;
            r_br    <= 1'b0;
            r_int   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_int <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cmd && cmd_blocks != 4'd0) begin
                        r_state <= REQ;
                        r_base  <= cmd_addr;
                        r_n     <= cmd_blocks;
                        r_blk   <= '0;
                        r_br    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                REQ: begin
                    if (BG) begin
                        r_state <= XFER;
                        r_beat  <= '0;
                        r_off   <= r_blk;
                    end
                end
                XFER: begin
                    // Lost grant: the current block is restarted from beat 0 once re-granted.
                    if (!BG) begin
                        r_state <= REQ;
                        r_beat  <= '0;
                    end else if (w_last_beat) begin
                        r_blk  <= r_blk + 4'd1;
                        r_beat <= '0;
                        if (w_last_blk) begin
                            r_state <= DONE;
                            r_br    <= 1'b0;
                            r_int   <= 1'b1;
                        end else if (PREEMPT) begin
                            r_state <= GAP;
                            r_br    <= 1'b0;
                        end else begin
                            r_off <= r_blk + 4'd1;
                        end
                    end else begin
                        r_beat <= r_beat + 4'd1;
                    end
                end
                GAP: begin
                    r_state <= REQ;
                    r_br    <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign BR        = r_br;
    assign interrupt = r_int;
    assign busy      = r_busy;
    assign offset    = r_off;
    assign d_writeM  = w_own ? 1'b1 : 1'bz;
    assign d_address = w_own ? r_base + {10'd0, r_blk, 2'd0} : 16'bz;
    assign d_data    = w_own ? edata : 64'bz;
endmodule

// File: tb/tb_dma_block_writer.sv
// tb_dma_block_writer: runs a preempting and a bus-holding instance side by side and checks
// every write and each finished transfer against a block-list model of the transfer.
module tb_dma_block_writer;
    localparam int WRC = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [3:0]  cmd_blocks = '0;
    logic        bg [2];
    logic [63:0] ed [2];
    wire         br0, br1, wm0, wm1, in0, in1, bz0, bz1;
    wire  [3:0]  of0, of1;
    wire  [15:0] da0, da1;
    wire  [63:0] dd0, dd1;

    dma_block_writer #(.WR_CYCLES(WRC), .PREEMPT(1'b1)) u_pre (
        .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_blocks(cmd_blocks),
        .BR(br0), .BG(bg[0]), .edata(ed[0]), .offset(of0), .d_writeM(wm0), .d_address(da0),
        .d_data(dd0), .interrupt(in0), .busy(bz0));
    dma_block_writer #(.WR_CYCLES(WRC), .PREEMPT(1'b0)) u_hold (
        .clk(clk), .reset_n(reset_n), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_blocks(cmd_blocks),
        .BR(br1), .BG(bg[1]), .edata(ed[1]), .offset(of1), .d_writeM(wm1), .d_address(da1),
        .d_data(dd1), .interrupt(in1), .busy(bz1));

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errs = 0;
    logic        br [2], wm [2], it [2], bs [2];
    logic [3:0]  of [2];
    logic [15:0] da [2];
    logic [63:0] dd [2];
    logic        last_br [2], last_int [2];
    int          run [2], run_off [2], ints [2], gaps [2], wcyc [2], drop [2], ndone [2];
    bit          dropped [2], busy_seen [2], br_seen [2];
    logic [15:0] done_a [2][16];
    logic [15:0] base = '0;
    logic [63:0] salt = 64'h1;
    int          drop_blk = -1;
    int          drop_beat = 0;
    int          rst_blk = -1;
    bit          inject = 1'b0;
    bit          did_inj = 1'b0;

    function automatic string tag(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
        end
    endtask

    task automatic sample();
        br[0] = br0; br[1] = br1; wm[0] = wm0; wm[1] = wm1;
        it[0] = in0; it[1] = in1; bs[0] = bz0; bs[1] = bz1;
        of[0] = of0; of[1] = of1; da[0] = da0; da[1] = da1; dd[0] = dd0; dd[1] = dd1;
    endtask

    task automatic clr();
        for (int i = 0; i < 2; i++) begin
            run[i] = 0; run_off[i] = 0; ints[i] = 0; gaps[i] = 0; wcyc[i] = 0; drop[i] = 0;
            ndone[i] = 0; dropped[i] = 1'b0; busy_seen[i] = 1'b0; br_seen[i] = 1'b0;
        end
    endtask

    // One clock: drive grant (BR delayed one cycle, unless a drop is forced) and device data, then check.
    task automatic cyc();
        @(negedge clk);
        sample();
        for (int i = 0; i < 2; i++) begin
            bg[i] = drop[i] > 0 ? 1'b0 : last_br[i];
            if (drop[i] > 0) drop[i]--;
            ed[i] = salt * (64'(of[i]) + 64'd1);
        end
        #1;
        sample();
        for (int i = 0; i < 2; i++) begin
            chk(tag("write_without_grant", i), 64'(wm[i] === 1'b1 && bg[i] !== 1'b1), 64'd0);
            chk(tag("br_outside_transfer", i), 64'(br[i] && (!bs[i] || it[i])), 64'd0);
            chk(tag("interrupt_width", i), 64'(last_int[i] && it[i]), 64'd0);
            if (wm[i] === 1'b1) begin
                wcyc[i]++;
                chk(tag("addr", i), 64'(da[i]), 64'(16'(base + 16'(of[i]) * 16'd4)));
                chk(tag("data", i), dd[i], salt * (64'(of[i]) + 64'd1));
                if (run[i] > 0 && int'(of[i]) != run_off[i]) run[i] = 0;
                run_off[i] = int'(of[i]);
                run[i]++;
                if (drop_blk == int'(of[i]) && run[i] == drop_beat && !dropped[i]) begin
                    drop[i] = 3;
                    dropped[i] = 1'b1;
                end
                if (run[i] == WRC) begin
                    if (ndone[i] < 16) done_a[i][ndone[i]] = da[i];
                    ndone[i]++;
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
            if (it[i]) ints[i]++;
            if (last_br[i] && !br[i] && !it[i] && bs[i]) gaps[i]++;
            busy_seen[i] |= bs[i];
            br_seen[i] |= br[i];
            last_br[i] = br[i];
            last_int[i] = it[i];
        end
    endtask

    task automatic reset_abort();
        reset_n = 1'b0;
        #1;
        sample();
        for (int i = 0; i < 2; i++) begin
            chk(tag("abort_br", i), 64'(br[i]), 64'd0);
            chk(tag("abort_busy", i), 64'(bs[i]), 64'd0);
            chk(tag("abort_int", i), 64'(it[i]), 64'd0);
            chk(tag("abort_offset", i), 64'(of[i]), 64'd0);
            chk(tag("abort_bus_released", i), 64'(wm[i] === 1'b1), 64'd0);
            chk(tag("abort_no_interrupt", i), 64'(ints[i]), 64'd0);
            last_br[i] = 1'b0;
            bg[i] = 1'b0;
            drop[i] = 0;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rst_blk = -1;
    endtask

    task automatic xfer(input logic [15:0] a, input logic [3:0] n);
        int t = 0;
        clr();
        base = a;
        salt = {$urandom, $urandom};
        cmd = 1'b1; cmd_addr = a; cmd_blocks = n;
        cyc();
        cmd = 1'b0;
        while ((bs[0] || bs[1]) && t < 600) begin
            if (inject && !did_inj && wm[0] === 1'b1) begin
                cmd = 1'b1; cmd_addr = ~a; cmd_blocks = 4'd15; did_inj = 1'b1;
            end
            if (rst_blk >= 0 && wm[0] === 1'b1 && int'(of[0]) == rst_blk) begin
                reset_abort();
                return;
            end
            cyc();
            cmd = 1'b0;
            t++;
        end
        chk("transfer_timeout", 64'(t >= 600), 64'd0);
        for (int i = 0; i < 2; i++) begin
            chk(tag("blocks_done", i), 64'(ndone[i]), 64'(n));
            for (int k = 0; k < int'(n); k++)
                chk(tag("block_addr", i), 64'(done_a[i][k]), 64'(16'(a + 16'(k * 4))));
            chk(tag("interrupts", i), 64'(ints[i]), 64'd1);
            chk(tag("br_gaps", i), 64'(gaps[i]), i == 0 ? 64'(n - 4'd1) : 64'd0);
            chk(tag("offset_hold", i), 64'(of[i]), 64'(n - 4'd1));
            chk(tag("grant_dropped", i), 64'(dropped[i]), 64'(drop_blk >= 0));
            chk(tag("write_cycles", i), 64'(wcyc[i]),
                64'(int'(n) * WRC + (drop_blk >= 0 ? drop_beat : 0)));
        end
    endtask

    initial begin
        logic [15:0] ra;
        logic [3:0]  rn;
        for (int i = 0; i < 2; i++) begin
            bg[i] = 1'b0; ed[i] = '0; last_br[i] = 1'b0; last_int[i] = 1'b0;
        end
        clr();
        repeat (3) @(negedge clk);
        #1;
        sample();
        for (int i = 0; i < 2; i++) begin
            chk(tag("reset_br", i), 64'(br[i]), 64'd0);
            chk(tag("reset_busy", i), 64'(bs[i]), 64'd0);
            chk(tag("reset_int", i), 64'(it[i]), 64'd0);
            chk(tag("reset_offset", i), 64'(of[i]), 64'd0);
            chk(tag("reset_bus_released", i), 64'(wm[i] === 1'b1), 64'd0);
        end
        reset_n = 1'b1;
        cyc();
        xfer(16'h01F4, 4'd3);
        drop_blk = 1; drop_beat = 2;
        xfer(16'h01F4, 4'd3);
        drop_blk = -1;
        clr();
        cmd = 1'b1; cmd_addr = 16'h1234; cmd_blocks = 4'd0;
        cyc();
        cmd = 1'b0;
        repeat (8) cyc();
        for (int i = 0; i < 2; i++) begin
            chk(tag("zero_blocks_busy", i), 64'(busy_seen[i]), 64'd0);
            chk(tag("zero_blocks_br", i), 64'(br_seen[i]), 64'd0);
            chk(tag("zero_blocks_int", i), 64'(ints[i]), 64'd0);
        end
        inject = 1'b1; did_inj = 1'b0;
        xfer(16'h3A50, 4'd2);
        inject = 1'b0;
        chk("cmd_injected_while_busy", 64'(did_inj), 64'd1);
        xfer(16'hFFFC, 4'd2);
        for (int r = 0; r < 6; r++) begin
            ra = 16'($urandom);
            rn = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                drop_blk = int'($urandom_range(0, int'(rn) - 1));
                drop_beat = int'($urandom_range(1, WRC - 1));
            end
            xfer(ra, rn);
            drop_blk = -1;
        end
        rst_blk = 2;
        xfer(16'h0400, 4'd4);
        cyc();
        xfer(16'h0800, 4'd4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
